// File: rtl/prm_oblgc_query_seq.sv
// -----------------------------------------------------------------------------
// prm_oblgc_query_seq
// Initiator side of a bank of combinational edge checkers. A query frame is a
// stream of 15-bit obstacle codes. Each accepted code is registered onto the
// checker inputs, and one cycle later the returned edge_mask vector is ORed
// into a per-frame collision bitmap. The bitmap is handed to the planner over
// a valid/ready handshake.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_i         begin a new frame (honoured in IDLE only)
//   code_valid_i    obstacle code available
//   code_ready_o    block accepts a code this cycle (RUN)
//   code_i          obstacle code, bit0=A .. bit14=O
//   code_last_i     code_i is the final code of the frame
//   chk_code_o      registered code driven to checker inputs A..O
//   edge_mask_i     edge_mask outputs of the checker bank, bit k = edge k
//   mask_valid_o    frame bitmap ready (DONE)
//   mask_ready_i    consumer takes the bitmap
//   mask_o          OR of all edge_mask vectors of the frame, 1 = blocked
//   code_cnt_o      codes accepted in current/last frame, saturating
//   busy_o          state != IDLE
// -----------------------------------------------------------------------------
module prm_oblgc_query_seq #(
    parameter int unsigned NUM_EDGES = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 code_valid_i,
    output logic                 code_ready_o,
    input  logic [14:0]          code_i,
    input  logic                 code_last_i,
    output logic [14:0]          chk_code_o,
    input  logic [NUM_EDGES-1:0] edge_mask_i,
    output logic                 mask_valid_o,
    input  logic                 mask_ready_i,
    output logic [NUM_EDGES-1:0] mask_o,
    output logic [CNT_W-1:0]     code_cnt_o,
    output logic                 busy_o
);

    localparam int unsigned CODE_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_code_ready;
    logic                  r_mask_valid;
    logic                  r_busy;
    logic                  r_s1_vld;
    logic [CODE_W-1:0]     r_chk_code;
    logic [NUM_EDGES-1:0]  r_mask;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_accept;
    logic                  w_clear;

    // Handshake qualifiers; r_code_ready is high exactly while in RUN.
    assign w_accept = code_valid_i & r_code_ready;
    assign w_clear  = (r_state == IDLE) & start_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_accept && code_last_i) begin
                    w_state_nxt = DRAIN;
                end
            end
            // Gives the last accepted code one cycle to produce its mask.
            DRAIN: begin
                w_state_nxt = DONE;
            end
            // A simultaneous start_i is deliberately not latched here.
            DONE: begin
                if (mask_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they track r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_ready <= 1'b0;
            r_mask_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_code_ready <= (w_state_nxt == RUN);
            r_mask_valid <= (w_state_nxt == DONE);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    // Checker-input stage: chk_code holds its last value when no code arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_code <= '0;
            r_s1_vld   <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_chk_code <= code_i;
            end
        end
    end

    // Frame accumulation: bitmap OR and saturating code counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (w_clear) begin
            r_mask <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_s1_vld) begin
                r_mask <= r_mask | edge_mask_i;
            end
            if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign code_ready_o = r_code_ready;
    assign mask_valid_o = r_mask_valid;
    assign busy_o       = r_busy;
    assign chk_code_o   = r_chk_code;
    assign mask_o       = r_mask;
    assign code_cnt_o   = r_cnt;

endmodule

// File: tb/tb_prm_oblgc_query_seq.sv
// -----------------------------------------------------------------------------
// tb_prm_oblgc_query_seq
// Directed bench for prm_oblgc_query_seq with an 8-edge checker model. Two
// instances share stimulus: u_dut (CNT_W=16) and u_sat (CNT_W=2) for the
// counter saturation case.
// -----------------------------------------------------------------------------
module tb_prm_oblgc_query_seq;

    localparam int unsigned NE = 8;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          code_valid_i;
    logic [14:0]   code_i;
    logic          code_last_i;
    logic          mask_ready_i;

    logic          code_ready_o, mask_valid_o, busy_o;
    logic [14:0]   chk_code_o;
    logic [NE-1:0] edge_mask, mask_o;
    logic [15:0]   code_cnt_o;

    logic          s_code_ready, s_mask_valid, s_busy;
    logic [14:0]   s_chk_code;
    logic [NE-1:0] s_edge_mask, s_mask;
    logic [1:0]    s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Combinational edge-checker model.
    function automatic logic [NE-1:0] chk_model(input logic [14:0] c);
        case (c)
            15'h0001: chk_model = 8'h03;
            15'h4000: chk_model = 8'h40;
            default:  chk_model = c[7:0];
        endcase
    endfunction

    assign edge_mask   = chk_model(chk_code_o);
    assign s_edge_mask = chk_model(s_chk_code);

    prm_oblgc_query_seq #(.NUM_EDGES(NE), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .code_valid_i(code_valid_i), .code_ready_o(code_ready_o),
        .code_i(code_i), .code_last_i(code_last_i), .chk_code_o(chk_code_o),
        .edge_mask_i(edge_mask), .mask_valid_o(mask_valid_o),
        .mask_ready_i(mask_ready_i), .mask_o(mask_o),
        .code_cnt_o(code_cnt_o), .busy_o(busy_o)
    );

    prm_oblgc_query_seq #(.NUM_EDGES(NE), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start_i(start_i),
        .code_valid_i(code_valid_i), .code_ready_o(s_code_ready),
        .code_i(code_i), .code_last_i(code_last_i), .chk_code_o(s_chk_code),
        .edge_mask_i(s_edge_mask), .mask_valid_o(s_mask_valid),
        .mask_ready_i(mask_ready_i), .mask_o(s_mask),
        .code_cnt_o(s_cnt), .busy_o(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i      = 1'b0;
        code_valid_i = 1'b0;
        code_i       = 15'h0;
        code_last_i  = 1'b0;
        mask_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({code_ready_o, mask_valid_o, busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000", {code_ready_o, mask_valid_o, busy_o});
        end
        n_checks++;
        if ({chk_code_o, mask_o, code_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got chk=%h mask=%h cnt=%0d exp all 0", chk_code_o, mask_o, code_cnt_o);
        end
    endtask

    task automatic test_basic_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++;
        if ({code_ready_o, busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_run got ready/busy=%b exp 11", {code_ready_o, busy_o});
        end
        code_valid_i = 1'b1; code_i = 15'h0001; code_last_i = 1'b0;
        tick();
        n_checks++;
        if (chk_code_o !== 15'h0001) begin
            n_fail++;
            $display("FAIL basic_chk_code got %h exp 0001", chk_code_o);
        end
        code_i = 15'h4000; code_last_i = 1'b1;
        tick();
        code_valid_i = 1'b0; code_last_i = 1'b0;
        n_checks++;
        if ({mask_valid_o, code_ready_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_drain got valid/ready=%b exp 00", {mask_valid_o, code_ready_o});
        end
        tick();
        n_checks++;
        if (mask_valid_o !== 1'b1 || mask_o !== 8'h43 || code_cnt_o !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_done got valid=%b mask=%h cnt=%0d exp 1 43 2", mask_valid_o, mask_o, code_cnt_o);
        end
        mask_ready_i = 1'b1;
        tick();
        mask_ready_i = 1'b0;
        n_checks++;
        if ({mask_valid_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_handshake got valid/busy=%b exp 00", {mask_valid_o, busy_o});
        end
    endtask

    task automatic test_single_code();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        code_valid_i = 1'b1; code_i = 15'h0012; code_last_i = 1'b1;
        tick();
        code_valid_i = 1'b0; code_last_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (mask_valid_o !== 1'b1 || mask_o !== 8'h12 || code_cnt_o !== 16'd1) begin
            n_fail++;
            $display("FAIL single_done got valid=%b mask=%h cnt=%0d exp 1 12 1", mask_valid_o, mask_o, code_cnt_o);
        end
        mask_ready_i = 1'b1;
        tick();
        mask_ready_i = 1'b0;
    endtask

    task automatic test_gapped_stall();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        code_valid_i = 1'b1; code_i = 15'h0101;
        tick();
        code_valid_i = 1'b0; code_i = 15'h0004;
        tick();
        code_valid_i = 1'b1; code_i = 15'h0208; code_last_i = 1'b1;
        tick();
        code_valid_i = 1'b0; code_last_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mask_valid_o !== 1'b1 || mask_o !== 8'h09 || code_cnt_o !== 16'd2) begin
                n_fail++;
                $display("FAIL gap_hold[%0d] got valid=%b mask=%h cnt=%0d exp 1 09 2", i, mask_valid_o, mask_o, code_cnt_o);
            end
            tick();
        end
        mask_ready_i = 1'b1;
        tick();
        mask_ready_i = 1'b0;
        n_checks++;
        if (mask_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_release got valid=%b exp 0", mask_valid_o);
        end
    endtask

    task automatic test_start_ignored();
        start_i = 1'b1;
        tick();
        code_valid_i = 1'b1; code_i = 15'h0003;
        tick();
        start_i = 1'b0;
        code_i = 15'h0030; code_last_i = 1'b1;
        tick();
        code_valid_i = 1'b0; code_last_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        n_checks++;
        if (mask_valid_o !== 1'b1 || mask_o !== 8'h33 || code_cnt_o !== 16'd2) begin
            n_fail++;
            $display("FAIL start_in_run got valid=%b mask=%h cnt=%0d exp 1 33 2", mask_valid_o, mask_o, code_cnt_o);
        end
        mask_ready_i = 1'b1;
        tick();
        start_i = 1'b0; mask_ready_i = 1'b0;
        n_checks++;
        if ({busy_o, mask_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_with_hs got busy/valid=%b exp 00", {busy_o, mask_valid_o});
        end
        tick();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_not_latched got busy=%b exp 0", busy_o);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || mask_o !== 8'h00 || code_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clear got busy=%b mask=%h cnt=%0d exp 1 00 0", busy_o, mask_o, code_cnt_o);
        end
    endtask

    // Continues from the RUN state left by test_start_ignored.
    task automatic test_mid_reset();
        code_valid_i = 1'b1;
        code_i = 15'h0011;
        tick();
        code_i = 15'h0022;
        tick();
        code_i = 15'h0044;
        tick();
        code_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({code_ready_o, mask_valid_o, busy_o} !== 3'b000 || chk_code_o !== 15'h0 ||
            mask_o !== 8'h00 || code_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_state got rdy/vld/busy=%b chk=%h mask=%h cnt=%0d exp 000 0 00 0",
                     {code_ready_o, mask_valid_o, busy_o}, chk_code_o, mask_o, code_cnt_o);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if ({mask_valid_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_after got valid/busy=%b exp 00", {mask_valid_o, busy_o});
        end
    endtask

    task automatic test_back_to_back_sat();
        logic [14:0] codes [6];
        codes = '{15'h0001, 15'h0002, 15'h0004, 15'h0008, 15'h0010, 15'h0020};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            code_valid_i = 1'b1;
            code_i       = codes[i];
            code_last_i  = (i == 5);
            tick();
        end
        code_valid_i = 1'b0; code_last_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (s_mask_valid !== 1'b1 || s_cnt !== 2'd3 || s_mask !== 8'h3F) begin
            n_fail++;
            $display("FAIL sat_cnt2 got valid=%b cnt=%0d mask=%h exp 1 3 3f", s_mask_valid, s_cnt, s_mask);
        end
        n_checks++;
        if (mask_valid_o !== 1'b1 || code_cnt_o !== 16'd6 || mask_o !== 8'h3F) begin
            n_fail++;
            $display("FAIL b2b_cnt16 got valid=%b cnt=%0d mask=%h exp 1 6 3f", mask_valid_o, code_cnt_o, mask_o);
        end
        mask_ready_i = 1'b1;
        tick();
        mask_ready_i = 1'b0;
        n_checks++;
        if ({mask_valid_o, s_mask_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_release got valid=%b%b exp 00", mask_valid_o, s_mask_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_code();
        test_gapped_stall();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
